// File: rtl/dtw_host_sequencer.sv
// Host-side sequencer for the two-feature DTW core: streams template/test samples
// into the core, runs the compute phase with a timeout, and returns the distance.
module dtw_host_sequencer #(
    parameter int unsigned SEQ_LEN        = 256,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter logic [3:0]  DONE_STATE     = 4'b1001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        reload_template,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] dtw_data_in,
    output logic [7:0]  dtw_data_addr,
    output logic [1:0]  dtw_sys_status,
    output logic        dtw_en,
    input  logic [3:0]  dtw_state_out,
    input  logic [31:0] dtw_out,
    output logic [31:0] result,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        busy,
    output logic        error
);

    localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  LAST_ADDR = 8'(SEQ_LEN - 1);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_TEMP = 2'b01;
    localparam logic [1:0] ST_TEST = 2'b10;
    localparam logic [1:0] ST_RUN  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_TEMP,
        LOAD_TEST,
        RUN,
        RESULT
    } state_t;

    state_t        state, state_n;
    logic [7:0]    cnt, cnt_n;
    logic [TW-1:0] tcnt, tcnt_n;

    logic [31:0] data_n;
    logic [7:0]  addr_n;
    logic [1:0]  status_n;
    logic        en_n;
    logic        s_ready_n;
    logic [31:0] result_n;
    logic        result_valid_n;
    logic        busy_n;
    logic        error_n;
    logic        wr;
    logic [1:0]  wr_status;

    // Core sys_status code presented while idling in a given state.
    function automatic logic [1:0] status_of(input state_t s);
        case (s)
            LOAD_TEMP: status_of = ST_TEMP;
            LOAD_TEST: status_of = ST_TEST;
            RUN:       status_of = ST_RUN;
            default:   status_of = ST_IDLE;
        endcase
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        tcnt_n         = tcnt;
        data_n         = dtw_data_in;
        addr_n         = dtw_data_addr;
        result_n       = result;
        result_valid_n = result_valid;
        error_n        = error;
        wr             = 1'b0;
        wr_status      = ST_IDLE;

        case (state)
            IDLE: begin
                if (start) begin
                    error_n = 1'b0;
                    state_n = reload_template ? LOAD_TEMP : LOAD_TEST;
                end
            end
            LOAD_TEMP, LOAD_TEST: begin
                tcnt_n = '0;
                if (s_valid && s_ready) begin
                    wr        = 1'b1;
                    wr_status = (state == LOAD_TEMP) ? ST_TEMP : ST_TEST;
                    data_n    = s_data;
                    addr_n    = cnt;
                    if (cnt == LAST_ADDR) begin
                        cnt_n   = '0;
                        state_n = (state == LOAD_TEMP) ? LOAD_TEST : RUN;
                    end else begin
                        cnt_n = cnt + 8'(1);
                    end
                end
            end
            RUN: begin
                tcnt_n = tcnt + TW'(1);
                // Done has priority over a coincident timeout.
                if (dtw_state_out == DONE_STATE) begin
                    result_n       = dtw_out;
                    result_valid_n = 1'b1;
                    state_n        = RESULT;
                end else if (tcnt == T_LAST) begin
                    error_n        = 1'b1;
                    result_n       = 32'hFFFF_FFFF;
                    result_valid_n = 1'b1;
                    state_n        = RESULT;
                end
            end
            RESULT: begin
                if (result_ready) begin
                    result_valid_n = 1'b0;
                    state_n        = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // A write beat carries its own phase code; otherwise follow the next state.
        if (wr) begin
            en_n     = 1'b1;
            status_n = wr_status;
        end else begin
            en_n     = (state_n == RUN);
            status_n = status_of(state_n);
        end

        s_ready_n = (state_n == LOAD_TEMP) || (state_n == LOAD_TEST);
        busy_n    = (state_n != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            tcnt           <= '0;
            s_ready        <= 1'b0;
            dtw_data_in    <= '0;
            dtw_data_addr  <= '0;
            dtw_sys_status <= ST_IDLE;
            dtw_en         <= 1'b0;
            result         <= '0;
            result_valid   <= 1'b0;
            busy           <= 1'b0;
            error          <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            tcnt           <= tcnt_n;
            s_ready        <= s_ready_n;
            dtw_data_in    <= data_n;
            dtw_data_addr  <= addr_n;
            dtw_sys_status <= status_n;
            dtw_en         <= en_n;
            result         <= result_n;
            result_valid   <= result_valid_n;
            busy           <= busy_n;
            error          <= error_n;
        end
    end

endmodule

// File: tb/tb_dtw_host_sequencer.sv
// Scoreboard bench for dtw_host_sequencer: expected core writes and results are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_dtw_host_sequencer;

    localparam int unsigned SEQ  = 256;
    localparam int unsigned TOUT = 100;
    localparam logic [3:0]  DONE = 4'b1001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        reload_template = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] dtw_data_in;
    logic [7:0]  dtw_data_addr;
    logic [1:0]  dtw_sys_status;
    logic        dtw_en;
    logic [3:0]  dtw_state_out;
    logic [31:0] dtw_out;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic        busy;
    logic        error;

    dtw_host_sequencer #(
        .SEQ_LEN(SEQ),
        .TIMEOUT_CYCLES(TOUT),
        .DONE_STATE(DONE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .reload_template(reload_template),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .dtw_data_in(dtw_data_in),
        .dtw_data_addr(dtw_data_addr),
        .dtw_sys_status(dtw_sys_status),
        .dtw_en(dtw_en),
        .dtw_state_out(dtw_state_out),
        .dtw_out(dtw_out),
        .result(result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .busy(busy),
        .error(error)
    );

    always #5 clk = ~clk;

    // Core model: reports done 50 cycles into compute when enabled.
    logic done_en = 1'b1;
    int   run_cnt = 0;
    always @(posedge clk) run_cnt <= (dtw_sys_status == 2'b11) ? run_cnt + 1 : 0;
    assign dtw_state_out = (done_en && run_cnt >= 50) ? DONE : 4'h0;
    assign dtw_out       = 32'h0000_1234;

    typedef struct packed {
        logic [1:0]  st;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic        err;
        logic [31:0] res;
    } res_t;

    wr_t  wq[$];
    res_t rq[$];
    wr_t  wexp;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_writes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // Monitor: core writes and result port.
    always @(negedge clk) begin
        if (!rst) begin
            if (dtw_en === 1'b1 && dtw_sys_status != 2'b11) begin
                n_writes++;
                if (wq.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    wexp = wq.pop_front();
                    check("wr_status", 32'(dtw_sys_status), 32'(wexp.st));
                    check("wr_addr", 32'(dtw_data_addr), 32'(wexp.addr));
                    check("wr_data", dtw_data_in, wexp.data);
                end
            end
            if (result_valid === 1'b1) begin
                if (rq.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    check("result", result, rq[0].res);
                    check("error", 32'(error), 32'(rq[0].err));
                    if (result_ready) void'(rq.pop_front());
                end
            end
        end
    end

    task automatic do_start(input bit reload, input bit exp_res, input res_t r);
        @(posedge clk); #1;
        start = 1'b1;
        reload_template = reload;
        if (exp_res) rq.push_back(r);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
    endtask

    // Streams nbeats samples starting at a negedge; returns at the negedge after the last accept.
    task automatic stream(input int nbeats, input bit with_temp, input bit stall);
        int  k = 0;
        int  p = 0;
        int  idx;
        bit  tmp;
        while (k < nbeats && p < 5000) begin
            tmp     = with_temp && (k < SEQ);
            idx     = tmp ? k : (with_temp ? k - SEQ : k);
            s_valid = stall ? ((p % 4 == 0) || (p % 4 == 3)) : 1'b1;
            s_data  = tmp ? 32'(32'h0001_0000 + idx) : 32'(32'h0002_0000 + idx);
            if (s_valid && s_ready) begin
                wq.push_back({(tmp ? 2'b01 : 2'b10), 8'(idx), s_data});
                k++;
            end
            @(negedge clk);
            p++;
        end
        s_valid = 1'b0;
        if (k < nbeats) fail_now("stream_budget_expired");
    endtask

    task automatic wait_result(output int cyc);
        cyc = 1;
        while (result_valid !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (result_valid !== 1'b1) fail_now("result_wait_expired");
    endtask

    task automatic take_result();
        @(posedge clk); #1;
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_result_valid", 32'(result_valid), 32'd0);
    endtask

    int cyc;
    int w0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_en", 32'(dtw_en), 32'd0);
        check("rst_status", 32'(dtw_sys_status), 32'd0);
        check("rst_addr", 32'(dtw_data_addr), 32'd0);
        check("rst_data", dtw_data_in, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full job with template load.
        w0 = n_writes;
        do_start(1'b1, 1'b1, '{err: 1'b0, res: 32'h0000_1234});
        check("load_busy", 32'(busy), 32'd1);
        stream(2 * SEQ, 1'b1, 1'b0);
        wait_result(cyc);
        check("job1_busy", 32'(busy), 32'd1);
        check("job1_writes", 32'(n_writes - w0), 32'd512);
        take_result();

        // Template reuse with a stalled stream.
        w0 = n_writes;
        do_start(1'b0, 1'b1, '{err: 1'b0, res: 32'h0000_1234});
        stream(SEQ, 1'b0, 1'b1);
        wait_result(cyc);
        check("job2_writes", 32'(n_writes - w0), 32'd256);
        take_result();

        // Timeout with the core never finishing.
        done_en = 1'b0;
        do_start(1'b0, 1'b1, '{err: 1'b1, res: 32'hFFFF_FFFF});
        stream(SEQ, 1'b0, 1'b0);
        wait_result(cyc);
        check("timeout_cycle", 32'(cyc), 32'd101);
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_result", result, 32'hFFFF_FFFF);

        // Result backpressure with a stray start.
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                @(posedge clk); #1;
                start = 1'b1;
                reload_template = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            @(negedge clk);
            check("bp_s_ready", 32'(s_ready), 32'd0);
            check("bp_en", 32'(dtw_en), 32'd0);
            check("bp_status", 32'(dtw_sys_status), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
        end
        take_result();
        @(negedge clk);
        check("post_stray_s_ready", 32'(s_ready), 32'd0);
        check("post_stray_busy", 32'(busy), 32'd0);
        check("error_sticky", 32'(error), 32'd1);

        // Next start clears error; reset in the middle of the test load.
        done_en = 1'b1;
        do_start(1'b0, 1'b0, '{err: 1'b0, res: 32'h0});
        check("start_clears_error", 32'(error), 32'd0);
        stream(101, 1'b0, 1'b0);
        check("abort_addr", 32'(dtw_data_addr), 32'd100);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_s_ready", 32'(s_ready), 32'd0);
        check("abort_en", 32'(dtw_en), 32'd0);
        check("abort_status", 32'(dtw_sys_status), 32'd0);
        check("abort_addr_zero", 32'(dtw_data_addr), 32'd0);
        check("abort_data", dtw_data_in, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result_valid", 32'(result_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fresh job restarts at address 0.
        w0 = n_writes;
        do_start(1'b1, 1'b1, '{err: 1'b0, res: 32'h0000_1234});
        stream(2 * SEQ, 1'b1, 1'b0);
        wait_result(cyc);
        check("job4_writes", 32'(n_writes - w0), 32'd512);
        take_result();

        repeat (3) @(negedge clk);
        check("wq_empty", 32'(wq.size()), 32'd0);
        check("rq_empty", 32'(rq.size()), 32'd0);
        check("total_writes", 32'(n_writes), 32'd1637);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dtw_host_sequencer.md
Name: dtw_host_sequencer

Overview:
- Host-side driver for the 32-bit, 256-point, two-feature DTW core.
- Accepts template and test sample streams on a valid/ready interface and writes them into the core over its data/address/status port.
- Commands the compute phase and waits for the core's done state, then captures the DTW distance.
- Returns the distance on a valid/ready result port. It sits between the AXI slave glue and the DTW core.

Parameters:
- SEQ_LEN, 256, samples per sequence; must be between 2 and 256.
- TIMEOUT_CYCLES, 200000, maximum cycles in compute before error; must be at least 1.
- DONE_STATE, 4'b1001, core state code meaning the result is ready.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle job request, sampled only in IDLE
- reload_template  in  1  sampled with start; 1 = load template then test, 0 = load test only
- s_data  in  32  sample word: two 16-bit features
- s_valid  in  1  sample valid
- s_ready  out  1  sample accepted when s_valid && s_ready
- dtw_data_in  out  32  to core data_in
- dtw_data_addr  out  8  to core data_addr
- dtw_sys_status  out  2  to core sys_status: 00 idle, 01 load template, 10 load test, 11 compute
- dtw_en  out  1  to core en
- dtw_state_out  in  4  from core
- dtw_out  in  32  from core
- result  out  32  captured DTW distance
- result_valid  out  1  result available
- result_ready  in  1  result consumed when result_valid && result_ready
- busy  out  1  high in every state except IDLE
- error  out  1  timeout flag, sticky until the next start

Behaviour:
- Reset, synchronous: FSM goes to IDLE, counters clear. All outputs are 0, except that error also clears.
- Start in IDLE:
  - start=1 clears error.
  - reload_template=1 goes to LOAD_TEMP. reload_template=0 goes to LOAD_TEST.
  - start outside IDLE is ignored.
- LOAD_TEMP and LOAD_TEST:
  - s_ready=1.
  - On each accepted beat, the next cycle registers dtw_data_in=s_data, dtw_data_addr=cnt, dtw_en=1, and dtw_sys_status=01 (LOAD_TEMP) or 10 (LOAD_TEST). Write latency is one cycle.
  - In cycles with no accepted beat, dtw_en=0. Address and data hold their last values.
  - cnt increments per accepted beat.
  - The beat at cnt=SEQ_LEN-1 ends the phase: cnt returns to 0 and s_ready drops the following cycle.
  - LOAD_TEMP then goes to LOAD_TEST. LOAD_TEST goes to RUN.
  - Gaps in s_valid are allowed and do not advance cnt.
- RUN:
  - dtw_sys_status=11, dtw_en=1, s_ready=0.
  - Timeout counter tcnt starts at 0 and increments each cycle.
  - When dtw_state_out==DONE_STATE, capture dtw_out into result on the same edge, set result_valid=1, and go to RESULT.
  - If tcnt reaches TIMEOUT_CYCLES-1 without done: error=1, result=32'hFFFF_FFFF, result_valid=1, go to RESULT.
  - If done and timeout occur in the same cycle, done wins and error stays 0.
- RESULT:
  - dtw_en=0, dtw_sys_status=00.
  - result and result_valid hold until result_ready=1, then result_valid=0 and the FSM goes to IDLE.
  - start in RESULT is ignored.
- Back-to-back jobs: start may be asserted in the cycle after returning to IDLE. With reload_template=0 the previously loaded template is reused.
- Reset mid-job: any state returns to IDLE on the next edge. Partial loads are discarded and the core sees dtw_en=0 and sys_status=00.
- Addresses are always in the range 0..SEQ_LEN-1 and never wrap inside a phase.

Test Plan:
- Full job: start with reload_template=1; stream template words k=0..255 as 32'h0001_0000+k and test words as 32'h0002_0000+k. Required: 512 writes, addr 0..255 in each phase with sys_status 01 then 10. Core model raises DONE_STATE 50 cycles into RUN with dtw_out=32'h0000_1234. Required: result=32'h1234, result_valid=1, busy=1 until result_ready.
- Template reuse: second start with reload_template=0. Required: sys_status is never 01, exactly 256 writes at 10, then RUN.
- Stalled stream: s_valid toggles 1,0,0,1 per cycle. Required: dtw_en pulses only for accepted beats, no address skipped or repeated, final address 255.
- Timeout: TIMEOUT_CYCLES=100 and the core never reaches done. Required: on cycle 100 of RUN, error=1, result=32'hFFFFFFFF. The next start clears error.
- Result backpressure and stray start: result_ready held 0 for 20 cycles with start pulsed meanwhile. Required: result stable, no new load begins, IDLE reached the cycle after result_ready=1.
- Reset mid-load at address 100 of the test phase. Required: next cycle all outputs are 0 and busy=0. A new job then restarts from address 0.
